// File: rtl/soc_pb_spi_flash_rd_if.sv
// Bundle of the read-request, byte-stream and SPI-master command/response channels
// of soc_pb_spi_flash_rd; the block itself uses the slave modport.
interface soc_pb_spi_flash_rd_if #(parameter int LEN_W = 16);
  logic             req_valid;
  logic             req_ready;
  logic [23:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic             rd_valid;
  logic             rd_ready;
  logic [7:0]       rd_data;
  logic             rd_last;
  logic             done;
  logic             pb_spi_cmd_valid;
  logic             pb_spi_cmd_ready;
  logic [4:0]       pb_spi_cmd_we_msk;
  logic [31:0]      pb_spi_din;
  logic [31:0]      pb_spi_dout;
  logic             pb_spi_valid;
  logic             pb_spi_ready;

  modport slave (
    input  req_valid, req_addr, req_len, rd_ready,
    input  pb_spi_cmd_ready, pb_spi_dout, pb_spi_valid,
    output req_ready, rd_valid, rd_data, rd_last, done,
    output pb_spi_cmd_valid, pb_spi_cmd_we_msk, pb_spi_din, pb_spi_ready
  );

  modport master (
    output req_valid, req_addr, req_len, rd_ready,
    output pb_spi_cmd_ready, pb_spi_dout, pb_spi_valid,
    input  req_ready, rd_valid, rd_data, rd_last, done,
    input  pb_spi_cmd_valid, pb_spi_cmd_we_msk, pb_spi_din, pb_spi_ready
  );
endinterface

// File: rtl/soc_pb_spi_flash_rd.sv
// SPI flash byte reader driving a bit-level SPI master one command at a time.
// Optional macro SOC_SPI_FLASH_FAST_READ_EN selects opcode 0x0B with a dummy byte.
module soc_pb_spi_flash_rd #(
  parameter int LEN_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  soc_pb_spi_flash_rd_if.slave bus
);

`ifdef SOC_SPI_FLASH_FAST_READ_EN
  localparam int CMD_BITS = 40;
`else
  localparam int CMD_BITS = 32;
`endif

  localparam logic [4:0]       MSK_CR       = 5'b00011;
  localparam logic [4:0]       MSK_DR       = 5'b00001;
  localparam logic [5:0]       LAST_CMD_BIT = 6'(CMD_BITS - 1);
  localparam logic [5:0]       LAST_RX_BIT  = 6'd7;
  localparam logic [LEN_W-1:0] LEN_ONE      = LEN_W'(1'b1);
  localparam logic [LEN_W-1:0] LEN_ZERO     = {LEN_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE, S_CS_ON, S_SEND, S_RECV, S_PUSH, S_CS_OFF, S_FIN
  } state_t;

  state_t              r_state;
  logic [5:0]          r_bit_cnt;
  logic [LEN_W-1:0]    r_rem;
  logic [CMD_BITS-1:0] r_shift;
  logic [23:0]         r_addr;
  logic                r_req_ready;
  logic                r_rd_valid;
  logic [7:0]          r_rd_data;
  logic                r_rd_last;
  logic                r_done;
  logic                r_cmd_valid;
  logic [4:0]          r_we_msk;
  logic [31:0]         r_din;
  logic                r_spi_ready;
  logic [CMD_BITS-1:0] w_cmd_word;
  logic                w_cmd_fire;
  logic                w_rsp;

  function automatic logic [31:0] cr_word(input logic cs);
    return {23'd0, cs, 8'd0};
  endfunction

  function automatic logic [31:0] dr_word(input logic mosi);
    return {24'd0, mosi, 7'd0};
  endfunction

`ifdef SOC_SPI_FLASH_FAST_READ_EN
  assign w_cmd_word = {8'h0B, r_addr, 8'h00};
`else
  assign w_cmd_word = {8'h03, r_addr};
`endif

  assign w_cmd_fire = r_cmd_valid & bus.pb_spi_cmd_ready;
  assign w_rsp      = r_spi_ready & bus.pb_spi_valid;

  assign bus.req_ready         = r_req_ready;
  assign bus.rd_valid          = r_rd_valid;
  assign bus.rd_data           = r_rd_data;
  assign bus.rd_last           = r_rd_last;
  assign bus.done              = r_done;
  assign bus.pb_spi_cmd_valid  = r_cmd_valid;
  assign bus.pb_spi_cmd_we_msk = r_we_msk;
  assign bus.pb_spi_din        = r_din;
  assign bus.pb_spi_ready      = r_spi_ready;

  // Read sequencer; a response that needs a follow-up command issues it on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 6'd0;
      r_rem       <= LEN_ZERO;
      r_shift     <= {CMD_BITS{1'b0}};
      r_addr      <= 24'd0;
      r_req_ready <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= 8'd0;
      r_rd_last   <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_we_msk    <= 5'd0;
      r_din       <= 32'd0;
      r_spi_ready <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_cmd_valid <= 1'b0;
        r_spi_ready <= 1'b1;
      end else if (w_rsp) begin
        r_spi_ready <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_addr      <= bus.req_addr;
            r_rem       <= bus.req_len;
            r_req_ready <= 1'b0;
            if (bus.req_len != LEN_ZERO) begin
              r_state     <= S_CS_ON;
              r_cmd_valid <= 1'b1;
              r_we_msk    <= MSK_CR;
              r_din       <= cr_word(1'b1);
            end else begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end
        end
        S_CS_ON: begin
          if (w_rsp) begin
            r_state     <= S_SEND;
            r_bit_cnt   <= 6'd0;
            r_shift     <= {w_cmd_word[CMD_BITS-2:0], 1'b0};
            r_cmd_valid <= 1'b1;
            r_we_msk    <= MSK_DR;
            r_din       <= dr_word(w_cmd_word[CMD_BITS-1]);
          end
        end
        S_SEND: begin
          if (w_rsp) begin
            r_cmd_valid <= 1'b1;
            r_we_msk    <= MSK_DR;
            if (r_bit_cnt == LAST_CMD_BIT) begin
              r_state   <= S_RECV;
              r_bit_cnt <= 6'd0;
              r_din     <= dr_word(1'b0);
            end else begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
              r_shift   <= {r_shift[CMD_BITS-2:0], 1'b0};
              r_din     <= dr_word(r_shift[CMD_BITS-1]);
            end
          end
        end
        S_RECV: begin
          if (w_rsp) begin
            if (r_bit_cnt == LAST_RX_BIT) begin
              r_state    <= S_PUSH;
              r_bit_cnt  <= 6'd0;
              r_rd_data  <= bus.pb_spi_dout[7:0];
              r_rd_valid <= 1'b1;
              r_rd_last  <= (r_rem == LEN_ONE);
            end else begin
              r_bit_cnt   <= r_bit_cnt + 6'd1;
              r_cmd_valid <= 1'b1;
              r_we_msk    <= MSK_DR;
              r_din       <= dr_word(1'b0);
            end
          end
        end
        S_PUSH: begin
          if (bus.rd_ready) begin
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rem       <= r_rem - LEN_ONE;
            r_cmd_valid <= 1'b1;
            if (r_rem == LEN_ONE) begin
              r_state  <= S_CS_OFF;
              r_we_msk <= MSK_CR;
              r_din    <= cr_word(1'b0);
            end else begin
              r_state  <= S_RECV;
              r_we_msk <= MSK_DR;
              r_din    <= dr_word(1'b0);
            end
          end
        end
        S_CS_OFF: begin
          if (w_rsp) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          r_done      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_cmd_valid <= 1'b0;
          r_spi_ready <= 1'b0;
          r_rd_valid  <= 1'b0;
          r_rd_last   <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
